// File: rtl/iir_dac_serializer.sv
`default_nettype none
// ============================================================================
// Module      : iir_dac_serializer
// Description : Output stage of the IIR low-pass cascade. Accepts signed
//               samples over a valid/ready handshake into a one-deep holding
//               register. Each sample is shifted MSB-first to a serial DAC
//               using SCLK / SYNC_N, then committed with an LDAC_N strobe.
// Ports       : clk        - system clock, rising edge
//               reset      - synchronous active-low reset
//               in_data    - sample from the filter cascade (DATA_W bits)
//               in_valid   - in_data is valid
//               in_ready   - holding register empty
//               dac_sclk   - serial clock, idles low
//               dac_sdata  - serial data, MSB first
//               dac_sync_n - frame enable, low for the whole shift phase
//               dac_ldac_n - latch strobe, CLK_DIV cycles wide after a frame
//               busy       - frame in progress (SHIFT or LATCH)
//               frame_done - one-cycle pulse when a frame completes
// Revision    : 1.0 - initial release
// ============================================================================
module iir_dac_serializer #(
  parameter int DATA_W     = 32,
  parameter int CLK_DIV    = 4,
  parameter int OFFSET_BIN = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              dac_sclk,
  output logic              dac_sdata,
  output logic              dac_sync_n,
  output logic              dac_ldac_n,
  output logic              busy,
  output logic              frame_done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  // Flipping the MSB converts two's complement to offset binary.
  localparam logic [DATA_W-1:0] LOAD_XOR =
    (OFFSET_BIN != 0) ? {1'b1, {(DATA_W-1){1'b0}}} : '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  // The MSB goes straight onto the pin at load time, so the shifter only
  // carries the remaining DATA_W-1 bits, next bit at its top.
  logic [DATA_W-2:0]   shreg_q, shreg_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                sclk_q, sclk_d;
  logic                sdata_q, sdata_d;
  logic                sync_n_q, sync_n_d;
  logic                ldac_n_q, ldac_n_d;
  logic                busy_q;
  logic                frame_done_q, frame_done_d;

  logic                tick;
  logic [DATA_W-1:0]   load_word;

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    shreg_d      = shreg_q;
    div_cnt_d    = div_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    sclk_d       = sclk_q;
    sdata_d      = sdata_q;
    sync_n_d     = sync_n_q;
    ldac_n_d     = ldac_n_q;
    frame_done_d = 1'b0;
    tick         = (div_cnt_q == DIV_LAST);
    load_word    = hold_q ^ LOAD_XOR;

    // in_ready is low while full, so this never collides with the drain.
    if (in_valid && !hold_full_q) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        div_cnt_d = '0;
        sclk_d    = 1'b0;
        sdata_d   = 1'b0;
        sync_n_d  = 1'b1;
        ldac_n_d  = 1'b1;
        if (hold_full_q) begin
          shreg_d     = load_word[DATA_W-2:0];
          sdata_d     = load_word[DATA_W-1];
          hold_full_d = 1'b0;
          sync_n_d    = 1'b0;
          bit_cnt_d   = BIT_LAST;
          state_d     = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (tick) begin
          div_cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else if (bit_cnt_q != '0) begin
            sclk_d    = 1'b0;
            sdata_d   = shreg_q[DATA_W-2];
            shreg_d   = shreg_q << 1;
            bit_cnt_d = bit_cnt_q - BIT_W'(1);
          end else begin
            sclk_d   = 1'b0;
            sync_n_d = 1'b1;
            ldac_n_d = 1'b0;
            state_d  = ST_LATCH;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      ST_LATCH: begin
        if (tick) begin
          div_cnt_d    = '0;
          ldac_n_d     = 1'b1;
          frame_done_d = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      default: begin
        div_cnt_d = '0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      shreg_q      <= '0;
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      sclk_q       <= 1'b0;
      sdata_q      <= 1'b0;
      sync_n_q     <= 1'b1;
      ldac_n_q     <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      shreg_q      <= shreg_d;
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      sclk_q       <= sclk_d;
      sdata_q      <= sdata_d;
      sync_n_q     <= sync_n_d;
      ldac_n_q     <= ldac_n_d;
      busy_q       <= (state_d != ST_IDLE);
      frame_done_q <= frame_done_d;
    end
  end

  assign in_ready   = !hold_full_q;
  assign dac_sclk   = sclk_q;
  assign dac_sdata  = sdata_q;
  assign dac_sync_n = sync_n_q;
  assign dac_ldac_n = ldac_n_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_iir_dac_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_iir_dac_serializer
// Description : Bench for iir_dac_serializer. Three instances: defaults,
//               OFFSET_BIN=1, and CLK_DIV=2. Frames are observed at the pins
//               and compared with expectations derived from sample values
//               and the divider setting.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iir_dac_serializer;

  localparam int DW    = 32;
  localparam int LIMIT = 4000;

  typedef struct {
    logic [31:0] word;
    int          nbits;
    int          sync_cyc;
    int          ldac_cyc;
    int          done_cnt;
    int          busy_cyc;
    int          sclk_hi;
    int          bad_sdata;
    int          start;
    bit          busy_end;
    bit          tmo;
  } frame_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] din [3];
  logic [2:0]  vld;
  wire  [2:0]  rdy, sclk, sdata, sync_n, ldac_n, busy, fdone;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  function automatic int cdiv(input int k);
    return (k == 2) ? 2 : 4;
  endfunction

  // Offset binary is the sample value plus half of the full range.
  function automatic logic [31:0] wire_word(input int k, input logic [31:0] s);
    return (k == 1) ? s + 32'h8000_0000 : s;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    iir_dac_serializer #(
      .DATA_W    (DW),
      .CLK_DIV   ((g == 2) ? 2 : 4),
      .OFFSET_BIN((g == 1) ? 1 : 0)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (din[g]),
      .in_valid  (vld[g]),
      .in_ready  (rdy[g]),
      .dac_sclk  (sclk[g]),
      .dac_sdata (sdata[g]),
      .dac_sync_n(sync_n[g]),
      .dac_ldac_n(ldac_n[g]),
      .busy      (busy[g]),
      .frame_done(fdone[g])
    );
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send_one(input int k, input logic [31:0] d, output int acc, output bit ok);
    int t = 0;
    ok = 1'b0;
    acc = 0;
    din[k] = d;
    vld[k] = 1'b1;
    while (!ok && t < LIMIT) begin
      if (rdy[k] === 1'b1) begin
        acc = cyc + 1;
        ok  = 1'b1;
      end
      @(negedge clk);
      t++;
    end
    vld[k] = 1'b0;
  endtask

  // Observes one frame at the pins; returns at the sample where LDAC_N rises.
  task automatic capture(input int k, output frame_t f);
    int   t = 0;
    logic ps, pd;
    f = '{word: '0, nbits: 0, sync_cyc: 0, ldac_cyc: 0, done_cnt: 0, busy_cyc: 0,
          sclk_hi: 0, bad_sdata: 0, start: 0, busy_end: 1'b0, tmo: 1'b0};
    while (sync_n[k] !== 1'b0 && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    if (t >= LIMIT) begin
      f.tmo = 1'b1;
      return;
    end
    f.start = cyc;
    ps = sclk[k];
    pd = sdata[k];
    while (sync_n[k] === 1'b0 && t < LIMIT) begin
      f.sync_cyc++;
      if (busy[k] === 1'b1)  f.busy_cyc++;
      if (sclk[k] === 1'b1)  f.sclk_hi++;
      if (fdone[k] === 1'b1) f.done_cnt++;
      if (sclk[k] === 1'b1 && ps === 1'b0) begin
        f.word = {f.word[30:0], sdata[k]};
        f.nbits++;
      end
      if (sdata[k] !== pd && !(ps === 1'b1 && sclk[k] === 1'b0)) f.bad_sdata++;
      ps = sclk[k];
      pd = sdata[k];
      @(negedge clk);
      t++;
    end
    while (ldac_n[k] === 1'b0 && t < LIMIT) begin
      f.ldac_cyc++;
      if (busy[k] === 1'b1)  f.busy_cyc++;
      if (fdone[k] === 1'b1) f.done_cnt++;
      @(negedge clk);
      t++;
    end
    if (fdone[k] === 1'b1) f.done_cnt++;
    f.busy_end = busy[k];
    f.tmo = (t >= LIMIT);
  endtask

  task automatic test_reset();
    int lows = 0;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) din[k] = $urandom;
    vld = 3'b111;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      tests++; if (rdy[k] !== 1'b1) begin fails++; $display("FAIL reset_ready[%0d]: got %b want 1", k, rdy[k]); end
      tests++; if (sclk[k] !== 1'b0) begin fails++; $display("FAIL reset_sclk[%0d]: got %b want 0", k, sclk[k]); end
      tests++; if (sdata[k] !== 1'b0) begin fails++; $display("FAIL reset_sdata[%0d]: got %b want 0", k, sdata[k]); end
      tests++; if (sync_n[k] !== 1'b1) begin fails++; $display("FAIL reset_sync_n[%0d]: got %b want 1", k, sync_n[k]); end
      tests++; if (ldac_n[k] !== 1'b1) begin fails++; $display("FAIL reset_ldac_n[%0d]: got %b want 1", k, ldac_n[k]); end
      tests++; if (busy[k] !== 1'b0) begin fails++; $display("FAIL reset_busy[%0d]: got %b want 0", k, busy[k]); end
      tests++; if (fdone[k] !== 1'b0) begin fails++; $display("FAIL reset_frame_done[%0d]: got %b want 0", k, fdone[k]); end
    end
    reset = 1'b1;
    vld   = 3'b000;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      tests++; if (rdy[k] !== 1'b1) begin fails++; $display("FAIL post_reset_ready[%0d]: got %b want 1", k, rdy[k]); end
    end
    repeat (20) begin
      if (sync_n !== 3'b111) lows++;
      @(negedge clk);
    end
    tests++; if (lows !== 0) begin fails++; $display("FAIL reset_no_frame: got %0d sync-low cycles want 0", lows); end
  endtask

  task automatic test_single();
    int     acc;
    bit     ok;
    frame_t f;
    logic [31:0] s = 32'hA5A5_0F0F;
    send_one(0, s, acc, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL single_accept: got %b want 1", ok); end
    tests++; if (rdy[0] !== 1'b0) begin fails++; $display("FAIL single_ready_low: got %b want 0", rdy[0]); end
    tests++; if (sync_n[0] !== 1'b1) begin fails++; $display("FAIL single_sync_early: got %b want 1", sync_n[0]); end
    capture(0, f);
    tests++; if (f.tmo !== 1'b0) begin fails++; $display("FAIL single_timeout: got %b want 0", f.tmo); end
    tests++; if (f.start !== acc + 1) begin fails++; $display("FAIL single_latency: got %0d want %0d", f.start - acc + 1, 2); end
    tests++; if (f.word !== wire_word(0, s)) begin fails++; $display("FAIL single_word: got %h want %h", f.word, wire_word(0, s)); end
    tests++; if (f.nbits !== DW) begin fails++; $display("FAIL single_nbits: got %0d want %0d", f.nbits, DW); end
    tests++; if (f.sync_cyc !== 2 * DW * 4) begin fails++; $display("FAIL single_sync_len: got %0d want %0d", f.sync_cyc, 2 * DW * 4); end
    tests++; if (f.sclk_hi !== DW * 4) begin fails++; $display("FAIL single_sclk_high: got %0d want %0d", f.sclk_hi, DW * 4); end
    tests++; if (f.ldac_cyc !== 4) begin fails++; $display("FAIL single_ldac_len: got %0d want 4", f.ldac_cyc); end
    tests++; if (f.done_cnt !== 1) begin fails++; $display("FAIL single_done: got %0d want 1", f.done_cnt); end
    tests++; if (f.busy_cyc !== 2 * DW * 4 + 4) begin fails++; $display("FAIL single_busy_len: got %0d want %0d", f.busy_cyc, 2 * DW * 4 + 4); end
    tests++; if (f.busy_end !== 1'b0) begin fails++; $display("FAIL single_busy_end: got %b want 0", f.busy_end); end
    tests++; if (f.bad_sdata !== 0) begin fails++; $display("FAIL single_sdata_edge: got %0d bad changes want 0", f.bad_sdata); end
  endtask

  task automatic test_offset_bin();
    logic [31:0] vals [2];
    logic [31:0] want [2];
    int     acc;
    bit     ok;
    frame_t f;
    vals[0] = 32'h8000_0001; want[0] = 32'h0000_0001;
    vals[1] = 32'h7FFF_FFFF; want[1] = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      send_one(1, vals[i], acc, ok);
      capture(1, f);
      tests++; if (f.word !== want[i]) begin fails++; $display("FAIL offset_word[%0d]: got %h want %h", i, f.word, want[i]); end
      tests++; if (f.word !== wire_word(1, vals[i])) begin fails++; $display("FAIL offset_model[%0d]: got %h want %h", i, f.word, wire_word(1, vals[i])); end
      tests++; if (f.nbits !== DW) begin fails++; $display("FAIL offset_nbits[%0d]: got %0d want %0d", i, f.nbits, DW); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q [3];
    int     acc [3];
    frame_t f [3];
    int     n = 0;
    int     period = (2 * DW + 1) * cdiv(0) + 1;
    for (int i = 0; i < 3; i++) begin
      q[i] = $urandom;
      acc[i] = 0;
    end
    fork
      begin : drv
        int t = 0;
        while (n < 3 && t < 3 * LIMIT) begin
          din[0] = q[n];
          vld[0] = 1'b1;
          if (rdy[0] === 1'b1) begin
            acc[n] = cyc + 1;
            n++;
          end
          @(negedge clk);
          t++;
        end
        vld[0] = 1'b0;
      end
      begin : mon
        for (int i = 0; i < 3; i++) capture(0, f[i]);
      end
    join
    tests++; if (n !== 3) begin fails++; $display("FAIL b2b_accepted: got %0d want 3", n); end
    tests++; if (f[0].start !== acc[0] + 1) begin fails++; $display("FAIL b2b_first_start: got %0d want %0d", f[0].start, acc[0] + 1); end
    tests++; if (acc[1] !== f[0].start + 1) begin fails++; $display("FAIL b2b_second_accept: got %0d want %0d", acc[1], f[0].start + 1); end
    tests++; if (acc[2] !== f[1].start + 1) begin fails++; $display("FAIL b2b_third_stall: got %0d want %0d", acc[2], f[1].start + 1); end
    tests++; if (f[1].start - f[0].start !== period) begin fails++; $display("FAIL b2b_period1: got %0d want %0d", f[1].start - f[0].start, period); end
    tests++; if (f[2].start - f[1].start !== period) begin fails++; $display("FAIL b2b_period2: got %0d want %0d", f[2].start - f[1].start, period); end
    for (int i = 0; i < 3; i++) begin
      tests++; if (f[i].word !== q[i]) begin fails++; $display("FAIL b2b_word[%0d]: got %h want %h", i, f[i].word, q[i]); end
      tests++; if (f[i].done_cnt !== 1) begin fails++; $display("FAIL b2b_done[%0d]: got %0d want 1", i, f[i].done_cnt); end
    end
  endtask

  task automatic test_mid_reset();
    int   acc, rises = 0, t = 0, lows = 0, dones = 0;
    bit   ok1, ok2;
    logic ps;
    send_one(0, $urandom, acc, ok1);
    send_one(0, $urandom, acc, ok2);
    tests++; if ({ok1, ok2} !== 2'b11) begin fails++; $display("FAIL midrst_accepts: got %b want 11", {ok1, ok2}); end
    ps = sclk[0];
    while (rises < 10 && t < LIMIT) begin
      @(negedge clk);
      t++;
      if (sclk[0] === 1'b1 && ps === 1'b0) rises++;
      ps = sclk[0];
    end
    tests++; if (rises !== 10) begin fails++; $display("FAIL midrst_reach_bit10: got %0d rises want 10", rises); end
    reset = 1'b0;
    @(negedge clk);
    tests++; if (sync_n[0] !== 1'b1) begin fails++; $display("FAIL midrst_sync_n: got %b want 1", sync_n[0]); end
    tests++; if (sclk[0] !== 1'b0) begin fails++; $display("FAIL midrst_sclk: got %b want 0", sclk[0]); end
    tests++; if (ldac_n[0] !== 1'b1) begin fails++; $display("FAIL midrst_ldac_n: got %b want 1", ldac_n[0]); end
    tests++; if (busy[0] !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b want 0", busy[0]); end
    tests++; if (rdy[0] !== 1'b1) begin fails++; $display("FAIL midrst_ready: got %b want 1", rdy[0]); end
    reset = 1'b1;
    repeat (600) begin
      @(negedge clk);
      if (sync_n[0] !== 1'b1) lows++;
      if (fdone[0] !== 1'b0) dones++;
    end
    tests++; if (lows !== 0) begin fails++; $display("FAIL midrst_discard: got %0d sync-low cycles want 0", lows); end
    tests++; if (dones !== 0) begin fails++; $display("FAIL midrst_no_done: got %0d pulses want 0", dones); end
  endtask

  task automatic test_clkdiv2();
    int     acc;
    bit     ok;
    frame_t f;
    send_one(2, 32'h0000_0001, acc, ok);
    capture(2, f);
    tests++; if (f.word !== 32'h0000_0001) begin fails++; $display("FAIL div2_word: got %h want 00000001", f.word); end
    tests++; if (f.nbits !== DW) begin fails++; $display("FAIL div2_nbits: got %0d want %0d", f.nbits, DW); end
    tests++; if (f.sync_cyc !== 2 * DW * 2) begin fails++; $display("FAIL div2_sync_len: got %0d want %0d", f.sync_cyc, 2 * DW * 2); end
    tests++; if (f.sclk_hi !== DW * 2) begin fails++; $display("FAIL div2_sclk_high: got %0d want %0d", f.sclk_hi, DW * 2); end
    tests++; if (f.ldac_cyc !== 2) begin fails++; $display("FAIL div2_ldac_len: got %0d want 2", f.ldac_cyc); end
    tests++; if (f.done_cnt !== 1) begin fails++; $display("FAIL div2_done: got %0d want 1", f.done_cnt); end
  endtask

  task automatic test_random();
    int     acc;
    bit     ok;
    frame_t f;
    logic [31:0] s;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 2; i++) begin
        s = $urandom;
        send_one(k, s, acc, ok);
        capture(k, f);
        tests++; if (f.word !== wire_word(k, s)) begin fails++; $display("FAIL rand_word[%0d.%0d]: got %h want %h", k, i, f.word, wire_word(k, s)); end
        tests++; if (f.sync_cyc !== 2 * DW * cdiv(k)) begin fails++; $display("FAIL rand_sync_len[%0d.%0d]: got %0d want %0d", k, i, f.sync_cyc, 2 * DW * cdiv(k)); end
        tests++; if (f.ldac_cyc !== cdiv(k)) begin fails++; $display("FAIL rand_ldac_len[%0d.%0d]: got %0d want %0d", k, i, f.ldac_cyc, cdiv(k)); end
        tests++; if (f.bad_sdata !== 0) begin fails++; $display("FAIL rand_sdata_edge[%0d.%0d]: got %0d want 0", k, i, f.bad_sdata); end
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    vld   = 3'b000;
    for (int k = 0; k < 3; k++) din[k] = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_offset_bin();
    test_back_to_back();
    test_mid_reset();
    test_clkdiv2();
    test_random();
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", tests);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/iir_dac_serializer.md
Name: iir_dac_serializer

Overview:
- Output-end companion to the cascaded IIR low-pass filter. Takes 32-bit signed filtered samples through a valid/ready handshake.
- Buffers one sample and shifts it MSB-first to an external serial DAC using SCLK, SYNC_N and LDAC_N.
- Sits between the filter cascade output and the board DAC pins; it is the transmit side of the sample interface the filter receives on.

Parameters:
- DATA_W, 32, sample and frame width in bits.
- CLK_DIV, 4, clk cycles per SCLK half-period; minimum 2.
- OFFSET_BIN, 0, 1 = invert the sample MSB on load (two's complement to offset binary); 0 = send unchanged.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-low reset; reset==0 at a rising clk edge resets the block.
- in_data  input  DATA_W  signed sample from the filter cascade.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  holding register is empty; a transfer happens when in_valid && in_ready.
- dac_sclk  output  1  serial clock; idles low.
- dac_sdata  output  1  serial data, MSB first; changes only on dac_sclk falling edges or at frame start.
- dac_sync_n  output  1  active-low frame enable; low for the whole shift phase.
- dac_ldac_n  output  1  active-low latch strobe, CLK_DIV cycles wide, after each frame.
- busy  output  1  high in SHIFT or LATCH.
- frame_done  output  1  one-cycle pulse on the LATCH->IDLE transition.

Behaviour:
- Reset values: in_ready=1, dac_sclk=0, dac_sdata=0, dac_sync_n=1, dac_ldac_n=1, busy=0, frame_done=0. Holding register empty, state IDLE, div_cnt=0, bit_cnt=0.
- Reset mid-frame aborts immediately. The in-flight and buffered samples are discarded; the pins return to idle on the next edge.
- Holding register:
  - in_ready = !hold_full (direct from the register, no combinational path from in_valid).
  - On a transfer, hold <= in_data and hold_full <= 1.
  - A transfer and a drain can never happen in the same cycle, because in_ready=0 whenever hold is full.
- Divider: div_cnt counts 0..CLK_DIV-1 in SHIFT and LATCH; tick = (div_cnt==CLK_DIV-1). div_cnt clears on every state entry.
- FSM states: IDLE, SHIFT, LATCH.
- IDLE:
  - When hold_full=1: shreg <= hold with MSB inverted if OFFSET_BIN; hold_full <= 0; dac_sync_n <= 0; dac_sdata <= MSB of the loaded word; bit_cnt <= DATA_W-1; go to SHIFT.
  - Otherwise hold all outputs at idle values.
- SHIFT, on each tick:
  - If dac_sclk==0: dac_sclk <= 1 (the DAC samples on this rising edge).
  - If dac_sclk==1 and bit_cnt!=0: dac_sclk <= 0; shift shreg left; dac_sdata <= next bit; bit_cnt--.
  - If dac_sclk==1 and bit_cnt==0: dac_sclk <= 0; dac_sync_n <= 1; dac_ldac_n <= 0; go to LATCH.
- LATCH: on tick, dac_ldac_n <= 1, frame_done <= 1 for one cycle, go to IDLE.
- Timing:
  - SHIFT lasts exactly 2*DATA_W*CLK_DIV cycles; LATCH lasts CLK_DIV cycles; IDLE lasts at least 1 cycle between frames.
  - Back-to-back frame period = (2*DATA_W+1)*CLK_DIV + 1 clk cycles (261 at the defaults).
  - Latency from an accepted sample into an idle block to dac_sync_n falling = 2 cycles.
- in_ready may rise during SHIFT once hold is drained, so a second sample can be accepted while the first is shifting. A third sample stalls upstream until the next IDLE drain.
- busy = (state!=IDLE), registered.

Test Plan:
- Reset with in_valid=1 held -> all outputs at reset values, no transfer while reset=0; in_ready=1 the first cycle after reset=1.
- Single sample 0xA5A5_0F0F, OFFSET_BIN=0, CLK_DIV=4 -> 32 rising dac_sclk edges, dac_sync_n low for 256 cycles, bits sampled on rising edges = A5A50F0F MSB-first, then dac_ldac_n low 4 cycles, then frame_done pulse.
- Sample 0x8000_0001 with OFFSET_BIN=1 -> shifted word 0x0000_0001; sample 0x7FFF_FFFF -> shifted 0xFFFF_FFFF.
- in_valid held high with 3 samples queued -> 1st accepted at once, 2nd accepted during frame 1, 3rd stalled with in_ready=0 until the next IDLE; frame starts exactly 261 cycles apart.
- reset pulled low at bit 10 of a frame -> next edge dac_sync_n=1, dac_sclk=0, dac_ldac_n=1, buffered sample discarded, no frame_done.
- CLK_DIV=2 -> SCLK period 4 cycles, SHIFT 128 cycles, bits correct for 0x0000_0001 (only the final bit =1).
